// File: rtl/pkt_buf_wr_pkg.sv
// Shared constants and state encoding for the packet buffer-write stage.
package pkt_buf_wr_pkg;

   localparam int DATA_W = 134;
   localparam int ID_W   = 8;

   localparam logic [1:0] HEAD = 2'b01;
   localparam logic [1:0] MID  = 2'b11;
   localparam logic [1:0] TAIL = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_DROP  = 2'd2
   } pbw_state_e;

endpackage

// File: rtl/pkt_buf_wr_free_pool.sv
// Free-buffer bitmap with lowest-set-bit allocation, release and count.
module pbw_free_pool
   import pkt_buf_wr_pkg::*;
#(
   parameter int BUF_NUM = 16,
   parameter int BUF_AW  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alloc_i,
   input  logic              free_i,
   input  logic [BUF_AW-1:0] free_idx_i,
   input  logic              rel_wr_i,
   input  logic [ID_W-1:0]   rel_id_i,
   output logic              avail_o,
   output logic [BUF_AW-1:0] alloc_idx_o,
   output logic [4:0]        count_o
);

   localparam logic [ID_W-1:0] NUM_ID = ID_W'(BUF_NUM);
   localparam logic [5:0]      NUM_C  = 6'(BUF_NUM);

   logic [BUF_NUM-1:0] map_q, map_d;
   logic [4:0]         cnt_q, cnt_d;
   logic [BUF_AW-1:0]  rel_idx;
   logic               rel_ok;
   logic               do_alloc;
   logic [5:0]         sum;

   assign avail_o  = |map_q;
   assign do_alloc = alloc_i & avail_o;
   assign rel_idx  = rel_id_i[BUF_AW-1:0];
   assign count_o  = cnt_q;

   always_comb begin
      alloc_idx_o = '0;
      for (int i = BUF_NUM - 1; i >= 0; i--) begin
         if (map_q[i]) alloc_idx_o = BUF_AW'(i);
      end
   end

   // A release of the ID being freed as bad this cycle would count twice.
   always_comb begin
      rel_ok = 1'b0;
      if (rel_wr_i && (rel_id_i < NUM_ID)) begin
         rel_ok = !map_q[rel_idx] &&
                  !(free_i && (free_idx_i == rel_idx));
      end
   end

   always_comb begin
      map_d = map_q;
      if (do_alloc) map_d[alloc_idx_o] = 1'b0;
      if (free_i)   map_d[free_idx_i]  = 1'b1;
      if (rel_ok)   map_d[rel_idx]     = 1'b1;
      sum = {1'b0, cnt_q} + 6'(free_i) + 6'(rel_ok)
            - 6'(do_alloc);
      cnt_d = (sum > NUM_C) ? 5'(BUF_NUM) : sum[4:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         map_q <= {BUF_NUM{1'b1}};
         cnt_q <= 5'(BUF_NUM);
      end else begin
         map_q <= map_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pkt_buf_wr.sv
// Buffer-write stage: allocates buffers, writes lines, commits or drops.
// Define PKT_BUF_WR_STAT_EN to build the drop/commit counters.
module pkt_buf_wr
   import pkt_buf_wr_pkg::*;
#(
   parameter int BUF_NUM = 16,
   parameter int BUF_AW  = 4,
   parameter int LINE_AW = 7
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [DATA_W-1:0]         in_pbw_data,
   input  logic                      in_pbw_data_wr,
   input  logic                      in_pbw_valid,
   input  logic                      in_pbw_valid_wr,
   output logic [ID_W-1:0]           out_pbw_ID,
   output logic [4:0]                out_pbw_ID_count,
   output logic [BUF_AW+LINE_AW-1:0] out_pbw_mem_addr,
   output logic [DATA_W-1:0]         out_pbw_mem_data,
   output logic                      out_pbw_mem_wr,
   output logic [ID_W-1:0]           out_pbw_commit_ID,
   output logic [LINE_AW:0]          out_pbw_commit_len,
   output logic                      out_pbw_commit_wr,
   input  logic [ID_W-1:0]           in_pbw_rel_ID,
   input  logic                      in_pbw_rel_wr,
   output logic [15:0]               out_pbw_drop_cnt,
   output logic [15:0]               out_pbw_commit_cnt
);

   localparam int AW = BUF_AW + LINE_AW;

   pbw_state_e          state_q, state_d;
   logic [BUF_AW-1:0]   idx_q, idx_d;
   logic [LINE_AW:0]    line_q, line_d;
   logic                ovf_q, ovf_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic [AW-1:0]       addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                wr_q, wr_d;
   logic [ID_W-1:0]     cid_q, cid_d;
   logic [LINE_AW:0]    clen_q, clen_d;
   logic                cwr_q, cwr_d;

   logic                alloc, bfree, avail;
   logic                drop_inc, commit_inc;
   logic [BUF_AW-1:0]   alloc_idx;
   logic [1:0]          flags;
   logic                is_head, is_tail, full;

   assign flags   = in_pbw_data[DATA_W-1 -: 2];
   assign is_head = in_pbw_data_wr && (flags == HEAD);
   assign is_tail = in_pbw_data_wr && (flags == TAIL);
   assign full    = line_q[LINE_AW];

   pbw_free_pool #(
      .BUF_NUM(BUF_NUM),
      .BUF_AW (BUF_AW)
   ) u_pool (
      .clk        (clk),
      .rst_n      (rst_n),
      .alloc_i    (alloc),
      .free_i     (bfree),
      .free_idx_i (idx_q),
      .rel_wr_i   (in_pbw_rel_wr),
      .rel_id_i   (in_pbw_rel_ID),
      .avail_o    (avail),
      .alloc_idx_o(alloc_idx),
      .count_o    (out_pbw_ID_count)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      line_d     = line_q;
      ovf_d      = ovf_q;
      id_d       = id_q;
      addr_d     = addr_q;
      data_d     = data_q;
      wr_d       = 1'b0;
      cid_d      = cid_q;
      clen_d     = clen_q;
      cwr_d      = 1'b0;
      alloc      = 1'b0;
      bfree      = 1'b0;
      drop_inc   = 1'b0;
      commit_inc = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (is_head && avail) begin
               alloc   = 1'b1;
               idx_d   = alloc_idx;
               id_d    = ID_W'(alloc_idx);
               addr_d  = {alloc_idx, {LINE_AW{1'b0}}};
               data_d  = in_pbw_data;
               wr_d    = 1'b1;
               line_d  = (LINE_AW+1)'(1);
               ovf_d   = 1'b0;
               state_d = S_WRITE;
            end else if (is_head) begin
               drop_inc = 1'b1;
               state_d  = S_DROP;
            end
         end
         S_WRITE: begin
            // A head before the tail truncates the packet; it is not taken.
            if (is_head) begin
               bfree    = 1'b1;
               drop_inc = 1'b1;
               state_d  = S_IDLE;
            end else if (in_pbw_data_wr) begin
               if (full) begin
                  ovf_d = 1'b1;
               end else begin
                  wr_d   = 1'b1;
                  addr_d = {idx_q, line_q[LINE_AW-1:0]};
                  data_d = in_pbw_data;
                  line_d = line_q + 1'b1;
               end
               if (is_tail) begin
                  state_d = S_IDLE;
                  if (in_pbw_valid_wr && in_pbw_valid &&
                      !full && !ovf_q) begin
                     cwr_d      = 1'b1;
                     cid_d      = id_q;
                     clen_d     = line_q + 1'b1;
                     commit_inc = 1'b1;
                  end else begin
                     bfree    = 1'b1;
                     drop_inc = 1'b1;
                  end
               end
            end
         end
         S_DROP: begin
            if (is_tail) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         line_q  <= '0;
         ovf_q   <= 1'b0;
         id_q    <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         wr_q    <= 1'b0;
         cid_q   <= '0;
         clen_q  <= '0;
         cwr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         line_q  <= line_d;
         ovf_q   <= ovf_d;
         id_q    <= id_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         wr_q    <= wr_d;
         cid_q   <= cid_d;
         clen_q  <= clen_d;
         cwr_q   <= cwr_d;
      end
   end

   assign out_pbw_ID         = id_q;
   assign out_pbw_mem_addr   = addr_q;
   assign out_pbw_mem_data   = data_q;
   assign out_pbw_mem_wr     = wr_q;
   assign out_pbw_commit_ID  = cid_q;
   assign out_pbw_commit_len = clen_q;
   assign out_pbw_commit_wr  = cwr_q;

`ifdef PKT_BUF_WR_STAT_EN
   logic [15:0] drop_cnt_q, commit_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         drop_cnt_q   <= '0;
         commit_cnt_q <= '0;
      end else begin
         if (drop_inc)   drop_cnt_q   <= drop_cnt_q + 1'b1;
         if (commit_inc) commit_cnt_q <= commit_cnt_q + 1'b1;
      end
   end

   assign out_pbw_drop_cnt   = drop_cnt_q;
   assign out_pbw_commit_cnt = commit_cnt_q;
`else
   logic unused_stat;
   assign unused_stat        = drop_inc ^ commit_inc;
   assign out_pbw_drop_cnt   = '0;
   assign out_pbw_commit_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_buf_wr.sv
// Directed self-checking bench for pkt_buf_wr.
module tb_pkt_buf_wr;

   localparam int BUF_AW  = 4;
   localparam int LINE_AW = 7;
   localparam logic [1:0] HD = 2'b01;
   localparam logic [1:0] MD = 2'b11;
   localparam logic [1:0] TL = 2'b10;
`ifdef PKT_BUF_WR_STAT_EN
   localparam int STAT = 1;
`else
   localparam int STAT = 0;
`endif

   logic                      clk = 1'b0;
   logic                      rst_n = 1'b0;
   logic [133:0]              data = '0;
   logic                      data_wr = 1'b0;
   logic                      valid = 1'b0;
   logic                      valid_wr = 1'b0;
   logic [7:0]                id;
   logic [4:0]                id_count;
   logic [BUF_AW+LINE_AW-1:0] mem_addr;
   logic [133:0]              mem_data;
   logic                      mem_wr;
   logic [7:0]                commit_id;
   logic [LINE_AW:0]          commit_len;
   logic                      commit_wr;
   logic [7:0]                rel_id = '0;
   logic                      rel_wr = 1'b0;
   logic [15:0]               drop_cnt;
   logic [15:0]               commit_cnt;

   int checks = 0;
   int failures = 0;
   int pl = 0;
   int nwr;

   always #5 clk = ~clk;

   pkt_buf_wr dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .in_pbw_data       (data),
      .in_pbw_data_wr    (data_wr),
      .in_pbw_valid      (valid),
      .in_pbw_valid_wr   (valid_wr),
      .out_pbw_ID        (id),
      .out_pbw_ID_count  (id_count),
      .out_pbw_mem_addr  (mem_addr),
      .out_pbw_mem_data  (mem_data),
      .out_pbw_mem_wr    (mem_wr),
      .out_pbw_commit_ID (commit_id),
      .out_pbw_commit_len(commit_len),
      .out_pbw_commit_wr (commit_wr),
      .in_pbw_rel_ID     (rel_id),
      .in_pbw_rel_wr     (rel_wr),
      .out_pbw_drop_cnt  (drop_cnt),
      .out_pbw_commit_cnt(commit_cnt)
   );

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic ln(logic [1:0] f, logic vw, logic v,
                     logic rw, logic [7:0] rid);
      @(negedge clk);
      pl++;
      data     = {f, 132'(pl)};
      data_wr  = 1'b1;
      valid_wr = vw;
      valid    = v;
      rel_wr   = rw;
      rel_id   = rid;
      @(posedge clk);
      #1;
      data_wr  = 1'b0;
      valid_wr = 1'b0;
      valid    = 1'b0;
      rel_wr   = 1'b0;
   endtask

   task automatic rel(logic [7:0] rid);
      @(negedge clk);
      rel_wr = 1'b1;
      rel_id = rid;
      @(posedge clk);
      #1;
      rel_wr = 1'b0;
   endtask

   task automatic idle();
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_id", 32'(id), 0);
      chk("rst_count", 32'(id_count), 16);
      chk("rst_wr", 32'(mem_wr), 0);
      chk("rst_addr", 32'(mem_addr), 0);
      chk("rst_cwr", 32'(commit_wr), 0);
      chk("rst_drop", 32'(drop_cnt), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // 3-line good packet
      ln(HD, 0, 0, 0, 0);
      chk("a_wr0", 32'(mem_wr), 1);
      chk("a_addr0", 32'(mem_addr), 0);
      chk("a_id", 32'(id), 0);
      chk("a_count", 32'(id_count), 15);
      checks++;
      assert (mem_data === data) else begin
         failures++;
         $error("FAIL a_data: observed %h expected %h", mem_data, data);
      end
      ln(MD, 0, 0, 0, 0);
      chk("a_addr1", 32'(mem_addr), 1);
      ln(TL, 1, 1, 0, 0);
      chk("a_addr2", 32'(mem_addr), 2);
      chk("a_cwr", 32'(commit_wr), 1);
      chk("a_cid", 32'(commit_id), 0);
      chk("a_clen", 32'(commit_len), 3);
      chk("a_count2", 32'(id_count), 15);
      idle();
      chk("a_cwr_off", 32'(commit_wr), 0);
      chk("a_wr_off", 32'(mem_wr), 0);
      rel(8'd0);
      chk("a_rel", 32'(id_count), 16);

      // bad verdict
      ln(HD, 0, 0, 0, 0);
      chk("b_id", 32'(id), 0);
      chk("b_count", 32'(id_count), 15);
      ln(MD, 0, 0, 0, 0);
      ln(TL, 1, 0, 0, 0);
      chk("b_wr", 32'(mem_wr), 1);
      chk("b_addr", 32'(mem_addr), 2);
      chk("b_cwr", 32'(commit_wr), 0);
      chk("b_count2", 32'(id_count), 16);
      chk("b_drop", 32'(drop_cnt), 32'(STAT));

      // exhaust the pool
      for (int i = 0; i < 16; i++) begin
         ln(HD, 0, 0, 0, 0);
         chk("c_id", 32'(id), 32'(i));
         ln(TL, 1, 1, 0, 0);
         chk("c_cid", 32'(commit_id), 32'(i));
         chk("c_clen", 32'(commit_len), 2);
      end
      chk("c_empty", 32'(id_count), 0);
      ln(HD, 0, 0, 0, 0);
      chk("c_nowr", 32'(mem_wr), 0);
      chk("c_drop", 32'(drop_cnt), 32'(2 * STAT));
      ln(TL, 1, 1, 0, 0);
      chk("c_tl_nowr", 32'(mem_wr), 0);
      chk("c_tl_ncwr", 32'(commit_wr), 0);
      rel(8'd5);
      chk("c_rel5", 32'(id_count), 1);
      ln(HD, 0, 0, 0, 0);
      chk("c_id5", 32'(id), 5);
      chk("c_addr5", 32'(mem_addr), 5 * 128);
      chk("c_count0", 32'(id_count), 0);
      ln(TL, 1, 1, 0, 0);
      chk("c_cid5", 32'(commit_id), 5);

      // release and allocation in the same cycle
      rel(8'd7);
      chk("d_rel7", 32'(id_count), 1);
      ln(HD, 0, 0, 1, 8'd3);
      chk("d_id7", 32'(id), 7);
      chk("d_count", 32'(id_count), 1);
      ln(TL, 1, 1, 0, 0);
      chk("d_cid7", 32'(commit_id), 7);
      chk("d_ccnt", 32'(commit_cnt), 32'(19 * STAT));
      rel(8'd20);
      chk("d_rel_oor", 32'(id_count), 1);
      rel(8'd3);
      chk("d_rel_dup", 32'(id_count), 1);

      // 130-line packet overflows
      ln(HD, 0, 0, 0, 0);
      chk("e_id3", 32'(id), 3);
      nwr = int'(mem_wr);
      for (int i = 0; i < 128; i++) begin
         ln(MD, 0, 0, 0, 0);
         nwr += int'(mem_wr);
      end
      chk("e_lastaddr", 32'(mem_addr), 511);
      ln(TL, 1, 1, 0, 0);
      nwr += int'(mem_wr);
      chk("e_nwr", 32'(nwr), 128);
      chk("e_cwr", 32'(commit_wr), 0);
      chk("e_count", 32'(id_count), 1);
      chk("e_drop", 32'(drop_cnt), 32'(3 * STAT));

      // new head truncates a packet in flight
      ln(HD, 0, 0, 0, 0);
      chk("f_id3", 32'(id), 3);
      ln(MD, 0, 0, 0, 0);
      ln(HD, 0, 0, 0, 0);
      chk("f_nowr", 32'(mem_wr), 0);
      chk("f_count", 32'(id_count), 1);
      chk("f_drop", 32'(drop_cnt), 32'(4 * STAT));
      ln(HD, 0, 0, 0, 0);
      chk("f_wr", 32'(mem_wr), 1);
      chk("f_addr", 32'(mem_addr), 3 * 128);
      ln(MD, 0, 0, 0, 0);

      // reset in the middle of a packet
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("g_wr", 32'(mem_wr), 0);
      chk("g_id", 32'(id), 0);
      chk("g_count", 32'(id_count), 16);
      chk("g_addr", 32'(mem_addr), 0);
      chk("g_cid", 32'(commit_id), 0);
      chk("g_drop", 32'(drop_cnt), 0);
      chk("g_ccnt", 32'(commit_cnt), 0);
      @(negedge clk);
      rst_n = 1'b1;
      ln(HD, 0, 0, 0, 0);
      chk("g_id0", 32'(id), 0);
      chk("g_wr0", 32'(mem_wr), 1);
      chk("g_count2", 32'(id_count), 15);
      ln(TL, 1, 1, 0, 0);
      chk("g_cid0", 32'(commit_id), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pkt_buf_wr.md
Name: pkt_buf_wr

Overview:
- Buffer-write stage directly downstream of the ingress buffer manager.
- Consumes the 134-bit packet stream plus the valid/valid_wr verdict, allocates a free buffer ID from a bitmap pool, and writes packet lines into the shared packet RAM at {buf_idx, line_idx}.
- Returns the allocated ID and the free-buffer count to the ingress stage for metadata construction.
- Commits good packets to the output scheduler; recycles IDs of bad or released packets.

Parameters:
- BUF_NUM, 16, number of packet buffers; range 2..31.
- BUF_AW, 4, log2(BUF_NUM); width of the RAM buffer-index field.
- LINE_AW, 7, line-index width; 128 lines x 16 B per buffer.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- in_pbw_data  in  134  packet line; [133:132] 01=head, 11=middle, 10=tail.
- in_pbw_data_wr  in  1  line strobe.
- in_pbw_valid  in  1  packet verdict; 1 = good.
- in_pbw_valid_wr  in  1  verdict strobe; coincides with the tail line.
- out_pbw_ID  out  8  allocated buffer ID, zero-extended.
- out_pbw_ID_count  out  5  current free-buffer count.
- out_pbw_mem_addr  out  BUF_AW+LINE_AW  RAM write address.
- out_pbw_mem_data  out  134  RAM write data.
- out_pbw_mem_wr  out  1  RAM write enable.
- out_pbw_commit_ID  out  8  ID of the committed packet.
- out_pbw_commit_len  out  LINE_AW+1  committed packet length in lines.
- out_pbw_commit_wr  out  1  commit strobe.
- in_pbw_rel_ID  in  8  ID released by the output scheduler.
- in_pbw_rel_wr  in  1  release strobe.
- out_pbw_drop_cnt  out  16  drop counter (see Optional Feature).
- out_pbw_commit_cnt  out  16  commit counter (see Optional Feature).

Behaviour:
- Reset, sampled on the clk edge: free_map = all BUF_NUM bits set; count = BUF_NUM; state IDLE.
- Reset values: every output 0, except out_pbw_ID_count = BUF_NUM.
- Reset mid-packet abandons the packet; the pool is fully restored.
- States: IDLE, WRITE, DROP.
- IDLE, on a head line (data_wr=1, flags=01):
  - If count>0: allocate the lowest set bit of free_map and clear it. Write line 0 at {idx,0} one cycle later (all memory outputs are registered, latency 1). out_pbw_ID updates on that same cycle and holds until the next allocation. Go to WRITE.
  - If count==0: no write, drop_cnt+1, go to DROP.
- IDLE, non-head lines: ignored.
- WRITE: each data_wr line is written at {idx, line_idx}; line_idx increments per line.
  - Overflow: if line_idx would exceed 2^LINE_AW-1, further writes are suppressed and an overflow flag is set.
  - Tail with valid_wr=1, valid=1, no overflow: commit. The cycle after the tail, commit_wr=1 for 1 cycle with commit_ID=ID and commit_len=line count. Go to IDLE.
  - Tail with valid=0 or overflow: ID returned to the pool, drop_cnt+1, no commit. Go to IDLE.
- WRITE, head line received before a tail: the current packet is treated as bad and its ID is freed. Go to IDLE; the new head is not accepted.
- DROP: lines are discarded. A tail returns to IDLE.
- Release: on in_pbw_rel_wr, set free_map bit rel_ID[BUF_AW-1:0].
  - Ignored if the bit is already set or rel_ID>=BUF_NUM.
  - Count is not changed when the release is ignored.
- Simultaneous events in one cycle (allocate, release, bad-packet free): all are applied. Count = count + frees - allocs, computed in one registered update.
- A same-cycle release is not visible to allocation until the next cycle.
- out_pbw_ID_count is registered and saturates at BUF_NUM.

Optional Feature:
- Macro: PKT_BUF_WR_STAT_EN.
- Defined: 16-bit wrapping counters.
  - out_pbw_drop_cnt counts dropped packets (no buffer, bad verdict, overflow, truncated by a new head).
  - out_pbw_commit_cnt counts commits.
- Undefined: both ports are tied to 0 and no counter registers exist.

Decomposition:
- Shared package holds:
  - Flag constants: HEAD=2'b01, MID=2'b11, TAIL=2'b10.
  - The state encoding.
  - Data width 134 and ID width 8.
- One sub-module, pbw_free_pool: free_map bitmap, lowest-set-bit priority encoder, alloc/release logic and count.

Test Plan:
- 3-line good packet from reset: writes at addr 0x000, 0x001, 0x002. Then commit_wr with ID=0, len=3; ID_count goes 16->15.
- Packet with valid=0 at the tail: lines written, no commit_wr; ID 0 returns; ID_count back to 16; drop_cnt=1 (STAT_EN defined).
- 16 back-to-back good packets: IDs 0..15, ID_count reaches 0. 17th packet produces no mem_wr and drop_cnt increments. Release ID 5, then the next packet gets ID 5.
- 130-line packet: only 128 writes; no commit; ID freed.
- Release of ID 3 in the same cycle as a head allocation with 1 buffer free (ID 7): allocates 7, frees 3; ID_count stays 1.
- rst_n low during the middle of a packet: all outputs 0, ID_count=16. The next head allocates ID 0.
